// File: rtl/ps_pkg.sv
// Shared program-sequencer constants: queue opcodes and queue geometry.
package ps_pkg;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [7:0] OP_ENQ  = 8'hC8;
  localparam logic [7:0] OP_CLR  = 8'hCF;
  localparam logic [7:0] OP_DEQ  = 8'hD8;
  localparam logic [7:0] OP_DROP = 8'hDF;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pc_queue_ctrl_if.sv
// PC queue bus: sequencer drives ir/pc, queue returns data, pointers and flags.
interface pc_queue_ctrl_if;
  import ps_pkg::*;

  logic [7:0] ir;
  logic [7:0] pc;
  logic [7:0] q_data;
  logic       q_valid;
  ptr_t       head;
  ptr_t       tail;
  cnt_t       count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  modport master (
    output ir, pc,
    input  q_data, q_valid, head, tail, count, full, empty, overflow, underflow
  );

  modport slave (
    input  ir, pc,
    output q_data, q_valid, head, tail, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/pc_queue_decode.sv
// Combinational queue-opcode decoder; at most one strobe is ever high.
module pc_queue_decode
  import ps_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic       o_enq,
  output logic       o_clr,
  output logic       o_deq,
  output logic       o_drop
);

  always_comb begin
    o_enq  = 1'b0;
    o_clr  = 1'b0;
    o_deq  = 1'b0;
    o_drop = 1'b0;
    case (i_ir)
      OP_ENQ:  o_enq  = 1'b1;
      OP_CLR:  o_clr  = 1'b1;
      OP_DEQ:  o_deq  = 1'b1;
      OP_DROP: o_drop = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_queue_ctrl.sv
// Four-entry circular PC buffer with head/tail/count tracking and sticky
// overflow/underflow flags, driven by opcodes decoded from the instruction word.
module pc_queue_ctrl
  import ps_pkg::*;
(
  input  logic            clk,
  input  logic            sync_reset,
  pc_queue_ctrl_if.slave  bus
);

  logic [7:0] r_mem [DEPTH];
  ptr_t       r_head;
  ptr_t       r_tail;
  cnt_t       r_count;
  logic [7:0] r_q_data;
  logic       r_q_valid;
  logic       r_overflow;
  logic       r_underflow;

  logic       w_enq;
  logic       w_clr;
  logic       w_deq;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;

  pc_queue_decode u_decode (
    .i_ir   (bus.ir),
    .o_enq  (w_enq),
    .o_clr  (w_clr),
    .o_deq  (w_deq),
    .o_drop (w_drop)
  );

  assign w_full  = (r_count == cnt_t'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = w_enq && !w_full;
  assign w_pop   = (w_deq || w_drop) && !w_empty;

  // Storage carries no reset; entries are meaningful only once written.
  always_ff @(posedge clk) begin
    if (!sync_reset && w_push) begin
      r_mem[r_tail] <= bus.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_q_data    <= '0;
      r_q_valid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (w_clr) begin
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (w_enq) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_tail  <= r_tail + ptr_t'(1);
          r_count <= r_count + cnt_t'(1);
        end
      end else if (w_deq || w_drop) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_head  <= r_head + ptr_t'(1);
          r_count <= r_count - cnt_t'(1);
          if (w_deq) begin
            r_q_data  <= r_mem[r_head];
            r_q_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.q_data    = r_q_data;
  assign bus.q_valid   = r_q_valid;
  assign bus.head      = r_head;
  assign bus.tail      = r_tail;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: doc/pc_queue_ctrl.md
# pc_queue_ctrl

Four-entry FIFO controller that buffers program-counter values for the program sequencer. It decodes the four queue opcodes (0xC8, 0xCF, 0xD8, 0xDF) from the instruction register and captures `pc` into a circular buffer. It returns the oldest entry on dequeue and tracks head/tail/occupancy with full, empty and sticky error flags. It sits beside the program sequencer: `pc` and `ir` come from the sequencer/instruction register, and `q_data` feeds back to the sequencer's `pc_q` input.

## Interface
- `DEPTH`, 4 — queue entries; fixed power of two, pointer width 2.
- `clk`  in  1  — system clock, rising edge.
- `sync_reset`  in  1  — synchronous, active-high reset.
- `ir`  in  8  — current instruction word; decoded every cycle.
- `pc`  in  8  — current program counter; value enqueued.
- `q_data`  out  8  — registered value of last dequeued entry.
- `q_valid`  out  1  — one-cycle pulse: `q_data` updated this cycle.
- `head`  out  2  — read pointer.
- `tail`  out  2  — write pointer.
- `count`  out  3  — occupancy, 0..4.
- `full`  out  1  — `count == 4`.
- `empty`  out  1  — `count == 0`.
- `overflow`  out  1  — sticky: enqueue attempted while full.
- `underflow`  out  1  — sticky: dequeue/drop attempted while empty.

## Operation
- Opcode decode, one command per cycle by construction:
  - 0xC8 ENQ: write `pc` to `mem[tail]`; `tail+1`; `count+1`.
  - 0xD8 DEQ: `q_data <= mem[head]`; `head+1`; `count-1`; pulse `q_valid`.
  - 0xDF DROP: `head+1`; `count-1`; `q_data` unchanged; no `q_valid`.
  - 0xCF CLR: `head`, `tail`, `count` set to 0; `overflow` and `underflow` cleared; `q_data` and memory unchanged.
  - Any other value: hold all state.
- Pointers are 2-bit and wrap 3→0 modulo 4 with no special case.
- ENQ while full: no write and no pointer/count change; set `overflow`.
- DEQ or DROP while empty: no pointer/count/`q_data` change; no `q_valid`; set `underflow`.
- Sticky flags clear only on CLR or reset.
- `full` and `empty` are combinational decodes of the registered `count`.
- Memory entries are not reset; their contents are undefined until written.

## Timing
- All state updates on the rising `clk` edge; `ir` and `pc` are sampled on that edge.
- ENQ latency: the entry is readable by a DEQ issued in the next cycle.
- DEQ latency: `q_data` and `q_valid` are valid 1 cycle after the edge that samples 0xD8.
- `q_valid` is high for exactly one cycle per successful DEQ.
- Back-to-back DEQs produce consecutive `q_valid` pulses.
- Reset is dominant over any opcode in the same cycle. After reset: `head=0`, `tail=0`, `count=0`, `q_data=8'h00`, `q_valid=0`, `overflow=0`, `underflow=0`, `empty=1`, `full=0`.
- Reset mid-sequence discards all entries; the next ENQ writes slot 0.
- DEQ at `count==4` followed by ENQ in the next cycle is legal; the slot freed by the DEQ is reused.

## Structure
- Shared package `ps_pkg`:
  - Opcode constants `OP_ENQ=8'hC8`, `OP_CLR=8'hCF`, `OP_DEQ=8'hD8`, `OP_DROP=8'hDF`.
  - `DEPTH` and pointer width.
- One natural sub-module, `pc_queue_decode`: combinational `ir` → one-hot {enq, clr, deq, drop}. It is reused by the sequencer's NOP-strobe logic.
- The top level holds the 4×8 register array, pointers, count, flags and the `q_data` register.

## Test plan
- Reset, then ENQ with `pc`=0x10, 0x11, 0x12, 0x13 → `count=4`, `full=1`, `tail=0` (wrapped).
- Four DEQs after that → `q_data` 0x10, 0x11, 0x12, 0x13 on successive cycles, 4 `q_valid` pulses, `empty=1`, `head=0`.
- ENQ 0x20 when full → contents unchanged; `overflow=1`; a later DEQ returns the oldest entry, not 0x20.
- DEQ when empty → `underflow=1`, no `q_valid`, `q_data` holds its previous value; CLR → both flags 0.
- ENQ 0x30, 0x31; DROP; DEQ → `q_data=0x31`; exactly one `q_valid` pulse.
- Wrap test: 6 alternating ENQ(0x40+i)/DEQ pairs → each DEQ returns the matching value; pointers wrap 3→0 with no error flags.
- Assert `sync_reset` together with ENQ while `count=2` → all outputs at reset values next cycle; `count=0`.
